// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// default memory timeout and the bundled stage-control word.
package hazard_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD = '0;

    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, pc_src: 1'b0
    };

    localparam ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, pc_src: 1'b1
    };

    // Load-use bubble: PC and IF/ID hold, ID/EX is cleared, older stages drain.
    localparam ctrl_t CTRL_BUBBLE = '{
        pc_write: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0, pc_src: 1'b0
    };

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline datapath,
// slave = hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rt;
    logic             EX_MEM_Branch;
    logic             EX_MEM_Zero;
    logic             MemReq;
    logic             MemReady;

    logic             PCWrite;
    logic             IF_ID_Enable;
    logic             ID_EX_Enable;
    logic             EX_MEM_Enable;
    logic             MEM_WB_Enable;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             PCSrc;
    logic             MemError;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ID_Rs, ID_Rt, ID_EX_MemRead, ID_EX_Rt, EX_MEM_Branch, EX_MEM_Zero,
               MemReq, MemReady,
        input  PCWrite, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PCSrc, MemError, StallCnt, FlushCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_EX_MemRead, ID_EX_Rt, EX_MEM_Branch, EX_MEM_Zero,
               MemReq, MemReady,
        output PCWrite, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PCSrc, MemError, StallCnt, FlushCnt
    );

endinterface

// File: rtl/sat_counter.sv
// Width-parameterised saturating event counter; updates on the falling clock
// edge like the rest of the pipeline, async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait/timeout handling, with saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_e  state;
    logic [7:0] wait_cnt;
    ctrl_t      ctrl;

    logic mem_stall;
    logic taken;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign mem_stall = hz.MemReq & ~hz.MemReady;
    assign taken     = hz.EX_MEM_Branch & hz.EX_MEM_Zero;
    assign load_use  = hz.ID_EX_MemRead & (hz.ID_EX_Rt != 5'd0) &
                       ((hz.ID_EX_Rt == hz.ID_Rs) | (hz.ID_EX_Rt == hz.ID_Rt));

    // Priority MemStall > Taken > LoadUse; everything is held low during reset.
    always_comb begin
        ctrl = CTRL_HOLD;
        if (reset && (state != FAULT)) begin
            if (mem_stall) begin
                ctrl = CTRL_HOLD;
            end else if (taken) begin
                ctrl = CTRL_BRANCH;
            end else if (load_use) begin
                ctrl = CTRL_BUBBLE;
            end else begin
                ctrl = CTRL_RUN;
            end
        end
    end

    assign stall_inc = (state != FAULT) & (mem_stall | (~taken & load_use));
    assign flush_inc = (state != FAULT) & ~mem_stall & taken;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign hz.PCWrite       = ctrl.pc_write;
    assign hz.IF_ID_Enable  = ctrl.if_id_en;
    assign hz.ID_EX_Enable  = ctrl.id_ex_en;
    assign hz.EX_MEM_Enable = ctrl.ex_mem_en;
    assign hz.MEM_WB_Enable = ctrl.mem_wb_en;
    assign hz.IF_ID_Flush   = ctrl.if_id_flush;
    assign hz.ID_EX_Flush   = ctrl.id_ex_flush;
    assign hz.EX_MEM_Flush  = ctrl.ex_mem_flush;
    assign hz.PCSrc         = ctrl.pc_src;
    assign hz.MemError      = reset & (state == FAULT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .cnt   (hz.StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .cnt   (hz.FlushCnt)
    );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max consecutive data-memory wait cycles before fault (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the saturating event counters.
REQ-003 SHALL have ports clk  in  1  single clock; all state updates on its falling edge, matching the pipeline registers.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports ID_EX_MemRead  in  1, ID_EX_Rt  in  5  load in EX and its destination.
REQ-007 SHALL have ports EX_MEM_Branch, EX_MEM_Zero  in  1 each  branch resolution in MEM.
REQ-008 SHALL have ports MemReq  in  1  (EX_MEM MemRead or MemWrite), MemReady  in  1  data-memory completion.
REQ-009 SHALL have outputs PCWrite, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable  1 each  stage enables.
REQ-010 SHALL have outputs IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  1 each  synchronous clear of that pipeline register.
REQ-011 SHALL have outputs PCSrc  1  select branch target; MemError  1  sticky timeout fault.
REQ-012 SHALL have outputs StallCnt, FlushCnt  CNT_W each  saturating event counters.

Function
REQ-013 SHALL implement states RUN, MEM_WAIT, FAULT; outputs are combinational from state and current inputs.
REQ-014 SHALL define MemStall = MemReq & ~MemReady; Taken = EX_MEM_Branch & EX_MEM_Zero; LoadUse = ID_EX_MemRead & (ID_EX_Rt != 0) & (ID_EX_Rt == ID_Rs | ID_EX_Rt == ID_Rt).
REQ-015 SHALL apply priority MemStall > Taken > LoadUse when these are asserted in the same cycle.
REQ-016 SHALL, in RUN with no condition, drive all enables 1, all flushes 0, PCSrc 0.
REQ-017 SHALL, on MemStall in RUN or MEM_WAIT, drive PCWrite and all four enables to 0 and all flushes to 0, and go to or remain in MEM_WAIT.
REQ-018 SHALL count wait cycles in MEM_WAIT starting from 0; when the count reaches MEM_TIMEOUT-1 with MemStall still 1, go to FAULT at the next edge.
REQ-019 SHALL, in MEM_WAIT with MemReady=1, return to RUN at the next edge, clear the wait count, and evaluate Taken/LoadUse that cycle as in RUN.
REQ-020 SHALL, on Taken without MemStall, drive PCSrc=1, PCWrite=1, all enables 1, and IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush = 1 for exactly that cycle.
REQ-021 SHALL, on LoadUse without MemStall or Taken, drive PCWrite=0, IF_ID_Enable=0, ID_EX_Flush=1 (bubble), with EX_MEM and MEM_WB enables 1.
REQ-022 SHALL, in FAULT, drive all enables and flushes to 0 and MemError=1, and leave FAULT only by reset.
REQ-023 SHALL increment StallCnt on each edge where a MemStall or LoadUse freeze was applied, and FlushCnt on each Taken flush; both saturate at all-ones.

Reset
REQ-024 SHALL, while reset=0, force state RUN, wait count 0, StallCnt 0, FlushCnt 0, MemError 0, PCWrite 0, all enables 0, all flushes 0, PCSrc 0.
REQ-025 SHALL take reset asynchronously in any state, including mid-MEM_WAIT and FAULT; the first cycle after release is RUN.

Structure
REQ-026 SHALL place state encoding (2-bit RUN/MEM_WAIT/FAULT) and the MEM_TIMEOUT default in a shared pipeline package.
REQ-027 SHALL implement the two event counters with one reusable sub-module, sat_counter (width-parameterised, increment enable, async active-low reset).

Verification
REQ-028 SHALL cover load-use: ID_EX_MemRead=1, ID_EX_Rt=5, ID_Rs=5 -> PCWrite=0, IF_ID_Enable=0, ID_EX_Flush=1 for one cycle, StallCnt=1.
REQ-029 SHALL cover the zero register: ID_EX_Rt=0, ID_Rs=0, ID_EX_MemRead=1 -> no stall, all enables 1.
REQ-030 SHALL cover branch plus load-use: Taken=1 and LoadUse=1 together -> PCSrc=1, three flushes 1, PCWrite=1, FlushCnt=1, StallCnt unchanged.
REQ-031 SHALL cover a memory wait: MemReq=1, MemReady=0 for 3 cycles then 1 -> enables 0 for 3 cycles, RUN on the 4th, StallCnt=3.
REQ-032 SHALL cover timeout: MemReady=0 held 16 cycles -> FAULT, MemError=1, frozen; reset low -> all outputs 0; release -> RUN, MemError=0.
REQ-033 SHALL cover saturation: with CNT_W=4, 20 load-use stalls -> StallCnt=15.
